// File: rtl/sipp_mem_arbiter_if.sv
// Two-requester memory arbiter bus: requester handshakes, read returns and the
// single-port memory connection, bundled so the arbiter and its environment share one view.
interface sipp_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
);
   logic                  req0;
   logic                  req1;
   logic                  we0;
   logic                  we1;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [ADDR_WIDTH-1:0] addr1;
   logic [DATA_WIDTH-1:0] wdata0;
   logic [DATA_WIDTH-1:0] wdata1;
   logic                  gnt0;
   logic                  gnt1;
   logic                  rvalid0;
   logic                  rvalid1;
   logic [DATA_WIDTH-1:0] rdata0;
   logic [DATA_WIDTH-1:0] rdata1;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_wr;
   logic                  mem_rd;
   logic [DATA_WIDTH-1:0] mem_w_data;
   logic [DATA_WIDTH-1:0] mem_r_data;
   logic                  busy;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_r_data,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
             mem_addr, mem_wr, mem_rd, mem_w_data, busy
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_r_data,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
             mem_addr, mem_wr, mem_rd, mem_w_data, busy
   );
endinterface

// File: rtl/sipp_mem_arbiter.sv
// Round-robin arbiter giving two requesters one-access-per-cycle use of a single
// memory port; reads return through registered rdata/rvalid one cycle after service.
module sipp_mem_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   sipp_mem_arbiter_if.slave  bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SERVE0 = 2'd1;
   localparam logic [1:0] SERVE1 = 2'd2;

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic                  last_gnt;
   logic                  lat_we;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_wdata;
   logic                  rvalid0_q;
   logic                  rvalid1_q;
   logic [DATA_WIDTH-1:0] rdata0_q;
   logic [DATA_WIDTH-1:0] rdata1_q;
   logic                  rd_done0;
   logic                  rd_done1;

   // The port being served is never re-picked on the next edge, which gives
   // strict alternation under contention and SERVE/IDLE spacing for a lone requester.
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE: begin
            if (bus.req0 && bus.req1) state_nxt = last_gnt ? SERVE0 : SERVE1;
            else if (bus.req0)        state_nxt = SERVE0;
            else if (bus.req1)        state_nxt = SERVE1;
         end
         SERVE0:  if (bus.req1) state_nxt = SERVE1;
         SERVE1:  if (bus.req0) state_nxt = SERVE0;
         default: state_nxt = IDLE;
      endcase
   end

   assign rd_done0 = (state == SERVE0) && !lat_we;
   assign rd_done1 = (state == SERVE1) && !lat_we;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         last_gnt  <= 1'b1;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         state     <= state_nxt;
         rvalid0_q <= rd_done0;
         rvalid1_q <= rd_done1;
         if (state_nxt == SERVE0) begin
            last_gnt  <= 1'b0;
            lat_we    <= bus.we0;
            lat_addr  <= bus.addr0;
            lat_wdata <= bus.wdata0;
         end else if (state_nxt == SERVE1) begin
            last_gnt  <= 1'b1;
            lat_we    <= bus.we1;
            lat_addr  <= bus.addr1;
            lat_wdata <= bus.wdata1;
         end
         if (rd_done0) rdata0_q <= bus.mem_r_data;
         if (rd_done1) rdata1_q <= bus.mem_r_data;
      end
   end

   // Memory strobes decode straight from state so an async reset drops them at once.
   assign bus.gnt0       = (state == SERVE0);
   assign bus.gnt1       = (state == SERVE1);
   assign bus.busy       = (state != IDLE);
   assign bus.mem_wr     = (bus.gnt0 || bus.gnt1) && lat_we;
   assign bus.mem_rd     = (bus.gnt0 || bus.gnt1) && !lat_we;
   assign bus.mem_addr   = lat_addr;
   assign bus.mem_w_data = lat_wdata;
   assign bus.rvalid0    = rvalid0_q;
   assign bus.rvalid1    = rvalid1_q;
   assign bus.rdata0     = rdata0_q;
   assign bus.rdata1     = rdata1_q;

endmodule

// File: tb/tb_sipp_mem_arbiter.sv
// Directed bench for sipp_mem_arbiter: a behavioural memory plus two scripted
// requesters, checking grants, strobes and read returns cycle by cycle.
module tb_sipp_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mem_init = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n0;
   int   n1;

   logic [15:0] mem [256];

   sipp_mem_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

   sipp_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Memory pattern A5xx makes every address hold a distinct, predictable word.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'hA500 | 16'(i);
      end else if (bus.mem_wr) begin
         mem[bus.mem_addr] <= bus.mem_w_data;
      end
   end

   assign bus.mem_r_data = mem[bus.mem_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

      #1 rst = 1'b0;
      mem_init = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_gnt0", bus.gnt0, 0);
      check("rst_gnt1", bus.gnt1, 0);
      check("rst_mem_wr", bus.mem_wr, 0);
      check("rst_mem_rd", bus.mem_rd, 0);
      check("rst_rvalid0", bus.rvalid0, 0);
      check("rst_rvalid1", bus.rvalid1, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_rdata0", bus.rdata0, 0);
      check("rst_rdata1", bus.rdata1, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_w_data", bus.mem_w_data, 0);
      mem_init = 1'b0;
      rst = 1'b1;

      // port 0 writes BEEF to 0x12, then reads it back
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h12; bus.wdata0 = 16'hBEEF;
      @(negedge clk);
      check("wr_gnt0", bus.gnt0, 1);
      check("wr_mem_wr", bus.mem_wr, 1);
      check("wr_mem_rd", bus.mem_rd, 0);
      check("wr_mem_addr", bus.mem_addr, 8'h12);
      check("wr_mem_w_data", bus.mem_w_data, 16'hBEEF);
      check("wr_busy", bus.busy, 1);
      bus.req0 = 1'b0;
      @(negedge clk);
      check("wr_done_mem_wr", bus.mem_wr, 0);
      check("wr_done_busy", bus.busy, 0);
      check("wr_committed", mem[8'h12], 16'hBEEF);
      check("idle_addr_hold", bus.mem_addr, 8'h12);
      bus.req0 = 1'b1; bus.we0 = 1'b0;
      @(negedge clk);
      check("rd_gnt0", bus.gnt0, 1);
      check("rd_mem_rd", bus.mem_rd, 1);
      check("rd_mem_wr", bus.mem_wr, 0);
      bus.req0 = 1'b0;
      @(negedge clk);
      check("rd_rvalid0", bus.rvalid0, 1);
      check("rd_rdata0", bus.rdata0, 16'hBEEF);
      check("rd_rvalid1", bus.rvalid1, 0);
      @(negedge clk);
      check("rd_rvalid0_pulse", bus.rvalid0, 0);
      check("rd_rdata0_hold", bus.rdata0, 16'hBEEF);

      // tie straight after reset: port 0 first, port 1 immediately after
      do_reset();
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h20;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h21;
      @(negedge clk);
      check("tie_gnt0", bus.gnt0, 1);
      check("tie_gnt1_low", bus.gnt1, 0);
      bus.req0 = 1'b0;
      @(negedge clk);
      check("tie_gnt1", bus.gnt1, 1);
      check("tie_gnt0_low", bus.gnt0, 0);
      check("tie_rvalid0", bus.rvalid0, 1);
      check("tie_rdata0", bus.rdata0, 16'hA520);
      bus.req1 = 1'b0;
      @(negedge clk);
      check("tie_rvalid1", bus.rvalid1, 1);
      check("tie_rvalid0_low", bus.rvalid0, 0);
      check("tie_rdata1", bus.rdata1, 16'hA521);
      check("tie_busy_low", bus.busy, 0);

      // both ports hold requests for 8 writes each
      n0 = 0; n1 = 0;
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h30; bus.wdata0 = 16'h0000;
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h31; bus.wdata1 = 16'h1000;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("fair_gnt0", bus.gnt0, (i % 2 == 0));
         check("fair_gnt1", bus.gnt1, (i % 2 == 1));
         if (bus.gnt0) begin
            n0++;
            bus.wdata0 = 16'(n0);
            if (n0 == 8) bus.req0 = 1'b0;
         end
         if (bus.gnt1) begin
            n1++;
            bus.wdata1 = 16'h1000 + 16'(n1);
            if (n1 == 8) bus.req1 = 1'b0;
         end
      end
      @(negedge clk);
      check("fair_busy_end", bus.busy, 0);
      check("fair_n0", n0, 8);
      check("fair_n1", n1, 8);
      check("fair_mem30", mem[8'h30], 16'h0007);
      check("fair_mem31", mem[8'h31], 16'h1007);

      // lone requester on port 1: three reads, one idle cycle between each
      n1 = 0;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h50;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("single_gnt1", bus.gnt1, (i % 2 == 0));
         check("single_busy", bus.busy, (i % 2 == 0));
         check("single_rvalid1", bus.rvalid1, (i % 2 == 1));
         check("single_gnt0", bus.gnt0, 0);
         if (i % 2 == 1) check("single_rdata1", bus.rdata1, 16'hA550);
         if (bus.gnt1) begin
            n1++;
            if (n1 == 3) bus.req1 = 1'b0;
         end
      end
      @(negedge clk);
      check("single_rvalid1_end", bus.rvalid1, 0);
      check("single_busy_end", bus.busy, 0);

      // reset lands in the middle of a port 0 write
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h40; bus.wdata0 = 16'h5555;
      @(negedge clk);
      check("abort_mem_wr_before", bus.mem_wr, 1);
      check("abort_gnt0_before", bus.gnt0, 1);
      #2 rst = 1'b0;
      #1;
      check("abort_mem_wr", bus.mem_wr, 0);
      check("abort_mem_rd", bus.mem_rd, 0);
      check("abort_gnt0", bus.gnt0, 0);
      check("abort_busy", bus.busy, 0);
      bus.req0 = 1'b0;
      @(negedge clk);
      check("abort_mem40", mem[8'h40], 16'hA540);
      check("abort_rdata0", bus.rdata0, 0);
      check("abort_rdata1", bus.rdata1, 0);
      check("abort_mem_addr", bus.mem_addr, 0);
      check("abort_mem_w_data", bus.mem_w_data, 0);
      check("abort_rvalid0", bus.rvalid0, 0);
      check("abort_rvalid1", bus.rvalid1, 0);
      rst = 1'b1;

      // port 0 write and port 1 read of the same address in the same cycle
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h60; bus.wdata0 = 16'h7777;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h60;
      @(negedge clk);
      check("mix_gnt0", bus.gnt0, 1);
      check("mix_gnt1_low", bus.gnt1, 0);
      check("mix_mem_wr", bus.mem_wr, 1);
      bus.req0 = 1'b0;
      @(negedge clk);
      check("mix_gnt1", bus.gnt1, 1);
      check("mix_mem_rd", bus.mem_rd, 1);
      check("mix_mem_addr", bus.mem_addr, 8'h60);
      bus.req1 = 1'b0;
      @(negedge clk);
      check("mix_rvalid1", bus.rvalid1, 1);
      check("mix_rdata1", bus.rdata1, 16'h7777);
      check("mix_rvalid0", bus.rvalid0, 0);
      @(negedge clk);
      check("mix_rvalid1_pulse", bus.rvalid1, 0);
      check("mix_busy_end", bus.busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
